// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8 data bits with mid-bit sampling; UART_RX_PARITY_EN adds a parity bit
module uart_rx #(
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] wait_clock,
    input  logic        rx,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        parity_err,
    output logic        busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic [2:0]  state;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] w_lat;
    logic [15:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        par_bad;
    logic        perr_q;
    logic        sample;

    assign sample = (cnt == 16'd0);
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            w_lat      <= 16'd0;
            cnt        <= 16'd0;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            par_bad    <= 1'b0;
            perr_q     <= 1'b0;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            perr_q     <= 1'b0;
            // Down-counter reloads on every sample point, so it never wraps inside a bit
            if (state != S_IDLE && state != S_BREAK)
                cnt <= sample ? w_lat - 16'd1 : cnt - 16'd1;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        w_lat   <= wait_clock;
                        cnt     <= (wait_clock >> 1) - 16'd1;
                        bit_cnt <= 3'd0;
                        par_bad <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (sample)
                        state <= rx_s ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (sample) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= S_AFTER_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (sample) begin
                        par_bad <= rx_s ^ (^shreg) ^ PARITY_ODD;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (sample) begin
                        if (rx_s) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            perr_q     <= par_bad;
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    // One frame_err per low period: wait for the line to recover
                    if (rx_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    logic unused_parity;
    assign unused_parity = PARITY_ODD ^ perr_q;
    assign parity_err    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
    localparam logic PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] wait_clock = 16'd16;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        frame_err;
    logic        parity_err;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    int         q_dv_t[$];
    logic [7:0] q_dv_d[$];
    int         q_fe_t[$];
    int         q_pe_t[$];

    uart_rx #(.PARITY_ODD(PODD)) dut (
        .clk(clk),
        .rst(rst),
        .wait_clock(wait_clock),
        .rx(rx),
        .data_out(data_out),
        .data_valid(data_valid),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            q_dv_t.push_back(cyc);
            q_dv_d.push_back(data_out);
        end
        if (frame_err) q_fe_t.push_back(cyc);
        if (parity_err) q_pe_t.push_back(cyc);
        if (data_valid || frame_err) begin
            n_checks++;
            if (data_valid && frame_err) begin
                n_fail++;
                $display("FAIL strobe_overlap: data_valid=1 frame_err=1 at cycle %0d, required never both", cyc);
            end
        end
    end

    // Cycles from the rx falling edge to the strobe, from the frame arithmetic
    function automatic int exp_lat(input int w);
        return 2 + (w >> 1) + NBITS * w + 1;
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par, input logic stop);
`ifdef UART_RX_PARITY_EN
        return {stop, (^b) ^ PODD ^ bad_par, b, 1'b0};
`else
        return {bad_par, stop, b, 1'b0};
`endif
    endfunction

    function automatic void clear_q();
        q_dv_t.delete();
        q_dv_d.delete();
        q_fe_t.delete();
        q_pe_t.delete();
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int w, input int hold, output int t0);
        t0 = cyc;
        for (int i = 0; i <= NBITS; i++) begin
            rx = frame[i];
            repeat (i == NBITS ? w + hold : w) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=1 after %0d cycles, required 0", max_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rx = 1'b1;
        wait_clock = 16'd16;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({data_out, data_valid, frame_err, parity_err, busy} !== 12'h000)
            begin n_fail++; $display("FAIL reset_state: got %h required 000", {data_out, data_valid, frame_err, parity_err, busy}); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b required 0", busy); end
        repeat (2) @(negedge clk);
        rx = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b required 1", busy); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({data_out, data_valid, frame_err, parity_err, busy} !== 12'h000)
            begin n_fail++; $display("FAIL midframe_reset: got %h required 000", {data_out, data_valid, frame_err, parity_err, busy}); end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (200) @(negedge clk);
        n_checks++;
        if (q_dv_t.size() + q_fe_t.size() + q_pe_t.size() != 0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL reset_no_strobe: strobes=%0d busy=%b required 0 and 0", q_dv_t.size() + q_fe_t.size() + q_pe_t.size(), busy); end
    endtask

    task automatic test_basic;
        int t0;
        int w;
        logic [7:0] b;
        clear_q();
        wait_clock = 16'd16;
        send_bits(make_frame(8'hA5, 1'b0, 1'b1), 16, 0, t0);
        wait_idle(100);
        n_checks++;
        if (q_dv_t.size() != 1 || q_fe_t.size() != 0) begin
            n_fail++; $display("FAIL a5_count: valid=%0d ferr=%0d required 1 and 0", q_dv_t.size(), q_fe_t.size());
        end else begin
            n_checks++;
            if (q_dv_d[0] !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h required a5", q_dv_d[0]); end
            n_checks++;
            if (q_dv_t[0] - t0 != 155) begin n_fail++; $display("FAIL a5_latency: got %0d required 155", q_dv_t[0] - t0); end
        end
        for (int k = 0; k < 6; k++) begin
            clear_q();
            w = (k == 0) ? 4 : (k == 1) ? 17 : int'($urandom_range(5, 40));
            b = 8'($urandom);
            wait_clock = 16'(w);
            fork
                send_bits(make_frame(b, 1'b0, 1'b1), w, 0, t0);
                begin
                    repeat (2 * w) @(negedge clk);
                    wait_clock = 16'($urandom_range(4, 300));
                end
            join
            wait_idle(4 * w + 20);
            n_checks++;
            if (q_dv_t.size() != 1) begin
                n_fail++; $display("FAIL rand_count w=%0d: got %0d strobes required 1", w, q_dv_t.size());
            end else begin
                n_checks++;
                if (q_dv_d[0] !== b) begin n_fail++; $display("FAIL rand_data w=%0d: got %h required %h", w, q_dv_d[0], b); end
                n_checks++;
                if (q_dv_t[0] - t0 != exp_lat(w)) begin n_fail++; $display("FAIL rand_latency w=%0d: got %0d required %0d", w, q_dv_t[0] - t0, exp_lat(w)); end
            end
        end
    endtask

    task automatic test_glitch;
        int t0;
        logic [7:0] b;
        clear_q();
        wait_clock = 16'd16;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_rise: got %b required 1", busy); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || q_dv_t.size() + q_fe_t.size() != 0)
            begin n_fail++; $display("FAIL glitch_reject: busy=%b strobes=%0d required 0 and 0", busy, q_dv_t.size() + q_fe_t.size()); end
        b = 8'($urandom);
        send_bits(make_frame(b, 1'b0, 1'b1), 16, 0, t0);
        wait_idle(100);
        n_checks++;
        if (q_dv_t.size() != 1 || q_dv_d.size() != 1 || q_dv_d[0] !== b)
            begin n_fail++; $display("FAIL glitch_recover: strobes=%0d required 1 with byte %h", q_dv_t.size(), b); end
    endtask

    task automatic test_frame_err;
        int t0;
        wait_clock = 16'd16;
        send_bits(make_frame(8'h5A, 1'b0, 1'b1), 16, 0, t0);
        wait_idle(100);
        clear_q();
        send_bits(make_frame(8'h3C, 1'b0, 1'b0), 16, 5 * 16, t0);
        wait_idle(100);
        n_checks++;
        if (q_fe_t.size() != 1 || q_dv_t.size() != 0) begin
            n_fail++; $display("FAIL ferr_count: ferr=%0d valid=%0d required 1 and 0", q_fe_t.size(), q_dv_t.size());
        end else begin
            n_checks++;
            if (q_fe_t[0] - t0 != exp_lat(16)) begin n_fail++; $display("FAIL ferr_latency: got %0d required %0d", q_fe_t[0] - t0, exp_lat(16)); end
        end
        n_checks++;
        if (data_out !== 8'h5A) begin n_fail++; $display("FAIL ferr_hold: data_out=%h required 5a", data_out); end
        clear_q();
        send_bits(make_frame(8'h81, 1'b0, 1'b1), 16, 0, t0);
        wait_idle(100);
        n_checks++;
        if (q_dv_t.size() != 1 || q_fe_t.size() != 0 || q_dv_d.size() != 1 || q_dv_d[0] !== 8'h81)
            begin n_fail++; $display("FAIL ferr_next: valid=%0d ferr=%0d required 1 and 0 with byte 81", q_dv_t.size(), q_fe_t.size()); end
    endtask

    task automatic test_large_w;
        int t0;
        logic [7:0] b;
        clear_q();
        b = 8'($urandom);
        wait_clock = 16'd2500;
        send_bits(make_frame(b, 1'b0, 1'b1), 2500, 0, t0);
        wait_idle(3000);
        n_checks++;
        if (q_dv_t.size() != 1 || q_dv_d[0] !== b || q_dv_t[0] - t0 != exp_lat(2500))
            begin n_fail++; $display("FAIL large_w: strobes=%0d required 1 with byte %h at latency %0d", q_dv_t.size(), b, exp_lat(2500)); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes[5];
        int t0s[5];
        int w;
        clear_q();
        w = int'($urandom_range(8, 32));
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55;
        bytes[3] = 8'($urandom); bytes[4] = 8'($urandom);
        wait_clock = 16'(w);
        for (int i = 0; i < 5; i++) send_bits(make_frame(bytes[i], 1'b0, 1'b1), w, 0, t0s[i]);
        wait_idle(4 * w + 20);
        n_checks++;
        if (q_dv_t.size() != 5) begin
            n_fail++; $display("FAIL b2b_count w=%0d: got %0d strobes required 5", w, q_dv_t.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (q_dv_d[i] !== bytes[i] || q_dv_t[i] - t0s[i] != exp_lat(w))
                    begin n_fail++; $display("FAIL b2b_%0d: got %h at %0d required %h at %0d", i, q_dv_d[i], q_dv_t[i] - t0s[i], bytes[i], exp_lat(w)); end
            end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int t0;
        logic [7:0] b;
        logic bad;
        wait_clock = 16'd16;
        for (int k = 0; k < 6; k++) begin
            clear_q();
            b = (k < 2) ? 8'h07 : 8'($urandom);
            bad = (k < 2) ? k[0] : 1'($urandom);
            send_bits(make_frame(b, bad, 1'b1), 16, 0, t0);
            wait_idle(100);
            n_checks++;
            if (q_dv_t.size() != 1 || q_dv_d[0] !== b)
                begin n_fail++; $display("FAIL parity_valid_%0d: strobes=%0d required 1 with byte %h", k, q_dv_t.size(), b); end
            n_checks++;
            if (q_pe_t.size() != (bad ? 1 : 0) || (bad && q_dv_t.size() == 1 && q_pe_t[0] != q_dv_t[0]))
                begin n_fail++; $display("FAIL parity_err_%0d: got %0d pulses required %0d aligned with data_valid", k, q_pe_t.size(), bad ? 1 : 0); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_large_w();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive engine for the serial link whose transmit timing is produced by `BAUD_GEN`. It recovers 8-bit characters from the asynchronous `rx` line and uses the same `wait_clock` divisor, in system clocks per bit. It has its own bit-timing counter with mid-bit sampling, so it needs no `bclk` tick. Each received byte is presented to the host logic with a one-cycle valid strobe and error flags.

## Interface
- `PARITY_ODD`, 0: parity sense when parity is compiled in (0 = even, 1 = odd); ignored otherwise.
- `clk`  in  1  system clock, 96 MHz nominal.
- `rst`  in  1  reset; synchronous, active-low.
- `wait_clock`  in  16  clocks per bit (96e6/9600 = 10000); legal range 4..65535.
- `rx`  in  1  asynchronous serial input, idle high.
- `data_out`  out  8  last received byte, LSB first on the line.
- `data_valid`  out  1  one-cycle strobe: `data_out` is a new good byte.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `parity_err`  out  1  one-cycle strobe: parity mismatch (0 when parity is compiled out).
- `busy`  out  1  high from start detection until the FSM returns to IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (`rx_s`). All decisions use `rx_s`, adding 2 cycles of latency.
- FSM states: IDLE, START, DATA, PARITY (compiled-in only), STOP, BREAK.
- **IDLE:** when `rx_s`==0, latch `wait_clock` into `w_lat`, clear the bit counter, go to START.
  - The latched value is used for the whole frame; changes to `wait_clock` mid-frame have no effect.
- **START:** at sample point S0, check `rx_s`.
  - If 1: false start. Go to IDLE with no strobe.
  - If 0: go to DATA.
- **DATA:** sample points S1..S8. Each sample shifts into the data register LSB first. After S8, go to PARITY if compiled in, else STOP.
- **PARITY:** sample point S9. Compare against the XOR of the data bits (XNOR when `PARITY_ODD`=1). Hold the result internally until STOP.
- **STOP:** at the stop sample point, check `rx_s`.
  - If 1: update `data_out`, pulse `data_valid`, and pulse `parity_err` if there was a mismatch. With a parity mismatch, `data_valid` still pulses and `data_out` is still updated. Go to IDLE.
  - If 0: pulse `frame_err`, leave `data_out` unchanged, no `data_valid`, go to BREAK.
- **BREAK:** wait until `rx_s`==1, then go to IDLE. A held-low line produces exactly one `frame_err`.
- Sample point arithmetic:
  - Let t=0 be the clock on which IDLE sees `rx_s`==0.
  - Sample point Sk falls at t = (w_lat>>1) + k*w_lat, with k = 0..9 (k = 0..10 with parity).
  - Counter width is 16 bits. The counter reloads at each sample point and never wraps within a bit.

## Timing
- Reset (`rst`==0 at a `clk` edge) sets all outputs as follows, from any state, including mid-frame:
  - `data_out`=0x00, `data_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - FSM goes to IDLE. The synchronizer presets to 1.
- Strobe timing:
  - Strobes are registered and asserted on the cycle after the stop sample point, high for exactly 1 cycle.
  - `data_valid` and `frame_err` are never high together.
- Latency from the `rx` falling edge to `data_valid` = 2 (sync) + (w_lat>>1) + 9*w_lat + 1 cycles. Add w_lat with parity.
- `busy` rises on the cycle after start detection. It falls on the cycle the FSM re-enters IDLE, which is the strobe cycle on a good frame.
- Back-to-back frames are supported: a start edge arriving the cycle after STOP→IDLE is detected normally, with no dead cycles beyond the FSM transition.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is start, 8 data, parity, stop.
  - The PARITY state exists and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined:
  - Frame is start, 8 data, stop (8N1).
  - No PARITY state; `parity_err` is tied to 0.
  - Stop sample point is S9.

## Test plan
- Reset with `wait_clock`=16, line idle → all outputs 0 and `busy`=0. Then assert reset mid-frame → outputs and FSM return to reset values on the next edge with no strobe.
- 8N1, `wait_clock`=16, send 0xA5 → one `data_valid` with `data_out`=0xA5 exactly at the computed latency (2+8+144+1 = 155 cycles). `frame_err`=0.
- Glitch: `rx` low for 4 cycles, `wait_clock`=16 → no strobe, `busy` drops, FSM is back in IDLE.
- Stop bit forced low on byte 0x3C → one `frame_err`, no `data_valid`, `data_out` holds the previous value. Line held low 5 bit-times then released → no further strobes; the next 0x81 is received correctly.
- `wait_clock`=10000 (96 MHz, 9600 baud), back-to-back 0x00, 0xFF, 0x55 → three `data_valid` strobes with matching bytes.
- With `UART_RX_PARITY_EN`, `PARITY_ODD`=0: send 0x07 with parity bit 1 → `data_valid` with 0x07, `parity_err`=0. Send the same with parity bit 0 → `data_valid` and `parity_err` both pulse.
